// File: rtl/fm_pkg.sv
// Shared types for the final-adder front end: generate/propagate/alive word,
// skid-buffer state encoding and the bit-0 carry-in merge helper.
package fm_pkg;

  localparam int unsigned GP_WIDTH = 16;

  typedef struct packed {
    logic [GP_WIDTH-1:0] g;
    logic [GP_WIDTH-1:0] p;
    logic [GP_WIDTH-1:0] a;
  } gp_word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  // Folding cin into bit 0 makes g[0] the true carry out of bit 0.
  function automatic logic carry_gen(input logic xb, input logic yb, input logic cb);
    return (xb & yb) | ((xb | yb) & cb);
  endfunction

endpackage

// File: rtl/gp_skid_buffer.sv
// Generic two-entry elastic register (main + skid). Both ready and valid
// come straight from flops; out_ready never reaches in_ready combinationally.
module gp_skid_buffer
  import fm_pkg::*;
#(
  parameter int unsigned W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout
);

  buf_state_e  state_r;
  buf_state_e  state_s;
  logic [W-1:0] main_r;
  logic [W-1:0] skid_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        xfer_in_s;
  logic        xfer_out_s;
  logic        load_main_s;
  logic        main_from_skid_s;
  logic        load_skid_s;

  assign xfer_in_s  = in_valid & in_ready_r;
  assign xfer_out_s = out_valid_r & out_ready;

  // Next-state and load-enable decode for the EMPTY/ONE/FULL occupancy machine.
  always_comb begin
    state_s          = state_r;
    load_main_s      = 1'b0;
    main_from_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (xfer_in_s) begin
          state_s     = ONE;
          load_main_s = 1'b1;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        if (xfer_in_s && xfer_out_s) begin
          state_s     = ONE;
          load_main_s = 1'b1;
        end else if (xfer_out_s) begin
          state_s = EMPTY;
        end else if (xfer_in_s) begin
          state_s     = FULL;
          load_skid_s = 1'b1;
        end else begin
          state_s = ONE;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (xfer_out_s) begin
          state_s          = ONE;
          load_main_s      = 1'b1;
          main_from_skid_s = 1'b1;
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s = EMPTY;
      end
    endcase
  end

  // Occupancy state plus registered handshake outputs derived from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s != FULL);
      out_valid_r <= (state_s != EMPTY);
    end
  end

  // Payload registers: main drives the outputs, skid catches the overflow word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r <= {W{1'b0}};
      skid_r <= {W{1'b0}};
    end else begin
      if (load_main_s) begin
        main_r <= main_from_skid_s ? skid_r : din;
      end
      if (load_skid_s) begin
        skid_r <= din;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign dout      = main_r;

endmodule

// File: rtl/gp_precompute.sv
// Elastic input stage of the final adder: per-bit g/p/a from the carry-save
// rows, registered through a skid buffer. Optional macro: CARRY_IN_EN.
module gp_precompute
  import fm_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
`ifdef CARRY_IN_EN
  input  logic             cin,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] a
`ifdef CARRY_IN_EN
  ,
  output logic             c0
`endif
);

`ifdef CARRY_IN_EN
  localparam int unsigned PW = 3 * WIDTH + 1;
`else
  localparam int unsigned PW = 3 * WIDTH;
`endif

  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] a_s;
  logic [PW-1:0]    payload_s;
  logic [PW-1:0]    buf_out_s;

  // Bitwise generate/propagate/alive; only bit 0 may see the carry-in.
  always_comb begin
    g_s = x & y;
    p_s = x ^ y;
    a_s = x | y;
`ifdef CARRY_IN_EN
    g_s[0] = carry_gen(x[0], y[0], cin);
`endif
  end

`ifdef CARRY_IN_EN
  assign payload_s = {g_s, p_s, a_s, cin};
`else
  assign payload_s = {g_s, p_s, a_s};
`endif

  gp_skid_buffer #(
    .W(PW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (payload_s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (buf_out_s)
  );

`ifdef CARRY_IN_EN
  assign {g, p, a, c0} = buf_out_s;
`else
  assign {g, p, a} = buf_out_s;
`endif

endmodule

// File: tb/tb_gp_precompute.sv
// Self-checking bench for gp_precompute (WIDTH=8): vector table, queue-based
// reference model with random traffic, backpressure and async-reset sequences.
module tb_gp_precompute;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] a;
`ifdef CARRY_IN_EN
  logic         c0;
`endif

  int checks   = 0;
  int failures = 0;

  gp_precompute #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
`ifdef CARRY_IN_EN
    .cin      (cin),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .g        (g),
    .p        (p),
    .a        (a)
`ifdef CARRY_IN_EN
    ,
    .c0       (c0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] a;
    logic         c0;
  } exp_t;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] a;
  } vec_t;

  exp_t q[$];

  // Reference: count ones per bit column; bit 0 also counts cin when enabled.
  function automatic exp_t ref_model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                     input logic ci);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      int n;
      n = int'(xv[i]) + int'(yv[i]);
      e.p[i] = (n == 1);
      e.a[i] = (n >= 1);
`ifdef CARRY_IN_EN
      if (i == 0) n = n + int'(ci);
`endif
      e.g[i] = (n >= 2);
    end
`ifdef CARRY_IN_EN
    e.c0 = ci;
`else
    e.c0 = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Entered at a falling edge: check against model, drive, leave at next falling edge.
  task automatic step(input logic v, input logic [W-1:0] xv, input logic [W-1:0] yv,
                      input logic ci, input logic rdy, output logic accepted);
    logic xin;
    logic xout;
    chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
    chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2)});
    if (q.size() > 0 && out_valid === 1'b1) begin
      chk("g", {24'd0, g}, {24'd0, q[0].g});
      chk("p", {24'd0, p}, {24'd0, q[0].p});
      chk("a", {24'd0, a}, {24'd0, q[0].a});
`ifdef CARRY_IN_EN
      chk("c0", {31'd0, c0}, {31'd0, q[0].c0});
`endif
    end
    in_valid  = v;
    x         = xv;
    y         = yv;
    cin       = ci;
    out_ready = rdy;
    xin  = v & (in_ready === 1'b1);
    xout = (out_valid === 1'b1) & rdy;
    if (xout && q.size() > 0) void'(q.pop_front());
    if (xin) q.push_back(ref_model(xv, yv, ci));
    accepted = xin;
    @(negedge clk);
  endtask

  vec_t tbl[6];
  logic acc;
  int   pushes;

  initial begin
    tbl[0] = '{8'hB5, 8'h6C, 8'h24, 8'hD9, 8'hFD};
    tbl[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    tbl[3] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    tbl[4] = '{8'hAA, 8'h55, 8'h00, 8'hFF, 8'hFF};
    tbl[5] = '{8'h0F, 8'h3C, 8'h0C, 8'h33, 8'h3F};

    // Reset held with in_valid asserted
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    x = 8'hB5; y = 8'h6C; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_gpa", {8'd0, g, p, a}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors: one accept, check one cycle later, then drain
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; x = tbl[i].x; y = tbl[i].y; cin = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("tbl_valid", {31'd0, out_valid}, 32'd1);
      chk("tbl_g", {24'd0, g}, {24'd0, tbl[i].g});
      chk("tbl_p", {24'd0, p}, {24'd0, tbl[i].p});
      chk("tbl_a", {24'd0, a}, {24'd0, tbl[i].a});
      @(negedge clk);
    end

`ifdef CARRY_IN_EN
    in_valid = 1'b1; x = 8'hB5; y = 8'h6C; cin = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("cin_g", {24'd0, g}, 32'h25);
    chk("cin_p", {24'd0, p}, 32'hD9);
    chk("cin_a", {24'd0, a}, 32'hFD);
    chk("cin_c0", {31'd0, c0}, 32'd1);
    @(negedge clk);
`endif

    // Streaming at full rate
    for (int i = 0; i < 100; i++)
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1, acc);
    repeat (2) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);

    // Backpressure: 5 stalled cycles, exactly two words absorbed
    pushes = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0, acc);
      if (acc) pushes++;
    end
    chk("bp_held", pushes, 32'd2);
    repeat (3) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);

    // Random valid/ready traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), acc);
    repeat (3) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);

    // Fill to FULL, then assert reset asynchronously mid-cycle
    repeat (2) step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0, acc);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_gpa", {8'd0, g, p, a}, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (3) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gp_precompute.md
# gp_precompute

Elastic input stage of the final carry-propagate adder. It takes the two carry-save rows from the compression tree and registers per-bit generate, propagate and alive vectors (g, p, a). These vectors feed the first row of prefix cells. A two-entry skid buffer decouples upstream and downstream valid/ready handshakes without a combinational ready path.

## Interface
Parameters:
- WIDTH, 16, operand and output vector width in bits (≥ 2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream word x/y is valid
- in_ready  out  1  stage can accept a word this cycle
- x  in  WIDTH  carry-save sum row
- y  in  WIDTH  carry-save carry row
- cin  in  1  adder carry-in (CARRY_IN_EN only)
- out_valid  out  1  g/p/a hold a valid word
- out_ready  in  1  prefix network consumes the word this cycle
- g  out  WIDTH  generate, g[i] = x[i] & y[i]
- p  out  WIDTH  propagate, p[i] = x[i] ^ y[i]
- a  out  WIDTH  alive, a[i] = x[i] | y[i]
- c0  out  1  registered cin, aligned with g/p/a (CARRY_IN_EN only)

Reset is asynchronous and active-low. All state uses the one clock.

## Operation
- The payload is computed combinationally from x/y/cin before it enters the buffer. The buffer stores {g,p,a[,c0]}, not x/y.
- Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
- The buffer has a main register (drives outputs) and a skid register.
- States and transitions:
  - EMPTY: no data held.
    - Transfer in goes to ONE, loading main.
  - ONE: main is valid.
    - In and out in the same cycle: stay in ONE, main reloads.
    - Out only: go to EMPTY.
    - In only: go to FULL, loading skid.
  - FULL: main and skid are valid.
    - Transfer out: skid moves to main, go to ONE.
    - No transfer in is possible while FULL.
- in_ready = !skid_valid, driven directly from a flop. No combinational path from out_ready.
- out_valid = main_valid.
- Data order is strictly FIFO. No word is dropped or duplicated.
- Outputs are stable while out_valid & !out_ready.
- Bits are independent, with no cross-bit arithmetic, so all vectors are exactly WIDTH bits. The only exception is bit 0 under CARRY_IN_EN.
- Reset asserted mid-operation discards all held words immediately, asynchronously.

## Timing
- Reset values: out_valid=0, g=p=a=0, c0=0, in_ready=1.
- Latency is 1 cycle. A word accepted on edge N appears with out_valid=1 after edge N, as long as main was free or is being drained at edge N.
- Sustained throughput is 1 word per cycle when out_ready is held at 1.
- When out_ready drops, at most one extra word is accepted into skid. in_ready falls on the next edge.
- in_ready returns to 1 on the edge after the skid word drains.
- When rst_n deasserts, the first accept is possible on the first rising edge after release.

## Configuration
- Macro: CARRY_IN_EN.
- Defined:
  - cin and c0 ports exist.
  - g[0] = (x[0]&y[0]) | ((x[0]|y[0]) & cin).
  - c0 carries cin alongside the word, so downstream sum[0] = p[0] ^ c0.
- Undefined:
  - cin and c0 ports are absent.
  - g[0] = x[0] & y[0].
  - The buffer payload is 3·WIDTH bits.

## Structure
- fm_pkg holds:
  - typedef gp_word_t, a packed struct {g,p,a} parameterised via WIDTH localparam usage.
  - The buffer state enum {EMPTY, ONE, FULL}.
- The prefix_cell stage imports the same package.
- Sub-module gp_skid_buffer holds the generic 2-entry elastic register, with payload width as a parameter. gp_precompute instantiates it once, after the bitwise logic.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0, g=p=a=0, in_ready=1. After release, the first word appears 1 cycle after accept.
- WIDTH=8, x=0xB5, y=0x6C, out_ready=1 → next cycle g=0x24, p=0xD9, a=0xFD, out_valid=1.
- CARRY_IN_EN, same x/y, cin=1 → g=0x25, p=0xD9, a=0xFD, c0=1.
- Streaming 100 random words with out_ready=1 → one word per cycle, in_ready stays 1, outputs match the reference model in order.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 → exactly 2 words held, in_ready=0 from the third cycle. On release, both words drain in order on consecutive cycles.
- Assert rst_n=0 asynchronously in FULL → out_valid drops without a clock edge, in_ready=1, no stale word reappears after release.
